// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if: request/response handshake between a client and ram_bus_master.
// Latency: none, plain wires.
// Backpressure: client holds req_valid until req_ready; responses and wdata_ready are unthrottled.
// Signals: req_valid/req_ready/req_we/req_addr/req_len/req_wdata (request),
//          wdata_ready (write byte consumed), rsp_valid/rsp_rdata (read beat), busy.
// Modports: master = client side, slave = ram_bus_master side.
interface ram_bus_master_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_len;
   logic [DATA_W-1:0] req_wdata;
   logic              wdata_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_len, req_wdata,
      input  req_ready, wdata_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_len, req_wdata,
      output req_ready, wdata_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master: bus initiator for the 2048x8 RAM (active-low CS, RW strobe, address, shared data bus).
// Latency: write beat occupies the cycle after acceptance; read response 3 cycles after acceptance.
// Backpressure: req_ready only in IDLE; rsp_valid/wdata_ready are one-cycle pulses with no backpressure.
// Ports: clk, rst (sync, active high); req_bus (slave side of ram_bus_master_if);
//        mem_addr, mem_rw (1=read), mem_cs (active low), mem_data (driven only in WR, else high-Z).
// Optional feature: define RAM_BURST_EN for bursts of req_len+1 beats (1..16); otherwise single beats.
module ram_bus_master #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   ram_bus_master_if.slave   req_bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rw,
   output logic              mem_cs,
   inout  wire  [DATA_W-1:0] mem_data
);
   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, TURN} state_t;

   state_t            state;
   logic [DATA_W-1:0] wdat;
   logic              oe;      // registered output enable for mem_data
   logic              more;    // another beat follows the current one

`ifdef RAM_BURST_EN
   logic [3:0] beat_cnt;       // beats remaining after the current one
   assign more = (beat_cnt != 4'd0);
`else
   logic [3:0] unused_req_len;
   assign unused_req_len = req_bus.req_len;
   assign more = 1'b0;
`endif

   assign req_bus.req_ready = (state == IDLE);
   assign req_bus.busy      = (state != IDLE);
   assign mem_data          = oe ? wdat : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         mem_cs              <= 1'b1;
         mem_rw              <= 1'b1;
         mem_addr            <= '0;
         oe                  <= 1'b0;
         wdat                <= '0;
         req_bus.rsp_valid   <= 1'b0;
         req_bus.rsp_rdata   <= '0;
         req_bus.wdata_ready <= 1'b0;
`ifdef RAM_BURST_EN
         beat_cnt            <= 4'd0;
`endif
      end else begin
         req_bus.rsp_valid   <= 1'b0;
         req_bus.wdata_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req_bus.req_valid) begin
                  mem_addr <= req_bus.req_addr;
                  mem_cs   <= 1'b0;
`ifdef RAM_BURST_EN
                  beat_cnt <= req_bus.req_len;
`endif
                  if (req_bus.req_we) begin
                     state               <= WR;
                     mem_rw              <= 1'b0;
                     oe                  <= 1'b1;
                     wdat                <= req_bus.req_wdata;
                     req_bus.wdata_ready <= 1'b1;
                  end else begin
                     state  <= RD_ADDR;
                     mem_rw <= 1'b1;
                  end
               end
            end
            WR: begin
               // Back-to-back write beats keep CS low and the bus driven.
               if (more) begin
`ifdef RAM_BURST_EN
                  beat_cnt <= beat_cnt - 4'd1;
`endif
                  mem_addr            <= mem_addr + ADDR_W'(1);
                  wdat                <= req_bus.req_wdata;
                  req_bus.wdata_ready <= 1'b1;
               end else begin
                  state  <= IDLE;
                  mem_cs <= 1'b1;
                  mem_rw <= 1'b1;
                  oe     <= 1'b0;
               end
            end
            RD_ADDR: begin
               state <= RD_DATA;
            end
            RD_DATA: begin
               // RAM drives the bus this cycle; capture and release CS for turnaround.
               req_bus.rsp_rdata <= mem_data;
               req_bus.rsp_valid <= 1'b1;
               mem_cs            <= 1'b1;
               state             <= TURN;
            end
            TURN: begin
               if (more) begin
`ifdef RAM_BURST_EN
                  beat_cnt <= beat_cnt - 4'd1;
`endif
                  mem_addr <= mem_addr + ADDR_W'(1);
                  mem_cs   <= 1'b0;
                  state    <= RD_ADDR;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               mem_cs <= 1'b1;
               mem_rw <= 1'b1;
               oe     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: self-checking bench for ram_bus_master with a behavioural RAM macro.
// Latency: expected bus schedule derived from the per-beat cycle counts of the protocol.
// Backpressure: requests are held until req_ready; responses are observed every cycle.
`timescale 1ns/1ps
module tb_ram_bus_master;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rw;
   logic              mem_cs;
   wire  [DATA_W-1:0] mem_data;

   ram_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_bus  (bus),
      .mem_addr (mem_addr),
      .mem_rw   (mem_rw),
      .mem_cs   (mem_cs),
      .mem_data (mem_data)
   );

   // RAM macro: writes at the end of a CS/WR cycle, registers the read address on the
   // first CS/RD cycle and drives the bus during the following cycle.
   logic [7:0] ram [0:2047];
   logic [7:0] ram_q;
   logic       ram_oe;
   assign mem_data = (ram_oe && !mem_cs) ? ram_q : 8'hzz;
   always @(posedge clk) begin
      if (!rst && !mem_cs && !mem_rw) ram[mem_addr] = mem_data;
      ram_oe <= !rst && !mem_cs && mem_rw && !ram_oe;
      if (!rst && !mem_cs && mem_rw && !ram_oe) ram_q <= ram[mem_addr];
   end

   // Reference memory contents, updated per accepted write beat.
   logic [7:0] model [0:2047];
   logic [7:0] txn_data [16];
   logic [7:0] first_rd;
   logic [7:0] rd_log [$];
   int         last_wait;
   int         n_cmp;
   int         n_mis;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one request from a negedge and check every cycle until the master is idle again.
   task automatic do_txn(input logic we, input logic [10:0] addr, input logic [3:0] len, input bit keep);
      int nb;
      logic [10:0] a;
`ifdef RAM_BURST_EN
      nb = int'(len) + 1;
`else
      nb = 1;
`endif
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_len   = len;
      bus.req_wdata = txn_data[0];
      bus.req_valid = 1'b1;
      last_wait = 0;
      while (!bus.req_ready && last_wait < 64) begin
         @(negedge clk);
         last_wait++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!keep) bus.req_valid = 1'b0;
      if (we) begin
         for (int i = 0; i < nb; i++) begin
            a = addr + 11'(i);
            check("wr_cs", 32'(mem_cs), 32'd0);
            check("wr_rw", 32'(mem_rw), 32'd0);
            check("wr_addr", 32'(mem_addr), 32'(a));
            check("wr_data", 32'(mem_data), 32'(txn_data[i]));
            check("wr_wdata_ready", 32'(bus.wdata_ready), 32'd1);
            check("wr_req_ready", 32'(bus.req_ready), 32'd0);
            model[a] = txn_data[i];
            if (i + 1 < nb) bus.req_wdata = txn_data[i+1];
            @(negedge clk);
         end
      end else begin
         for (int i = 0; i < nb; i++) begin
            a = addr + 11'(i);
            check("rda_cs", 32'(mem_cs), 32'd0);
            check("rda_rw", 32'(mem_rw), 32'd1);
            check("rda_addr", 32'(mem_addr), 32'(a));
            check("rda_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rda_busy", 32'(bus.busy), 32'd1);
            check("rda_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            check("rdd_cs", 32'(mem_cs), 32'd0);
            check("rdd_rw", 32'(mem_rw), 32'd1);
            check("rdd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rdd_wdata_ready", 32'(bus.wdata_ready), 32'd0);
            @(negedge clk);
            check("turn_cs", 32'(mem_cs), 32'd1);
            check("turn_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("turn_rdata", 32'(bus.rsp_rdata), 32'(model[a]));
            check("turn_req_ready", 32'(bus.req_ready), 32'd0);
            if (i == 0) first_rd = bus.rsp_rdata;
            rd_log.push_back(bus.rsp_rdata);
            @(negedge clk);
         end
      end
      check("end_req_ready", 32'(bus.req_ready), 32'd1);
      check("end_busy", 32'(bus.busy), 32'd0);
      check("end_cs", 32'(mem_cs), 32'd1);
      check("end_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("end_wdata_ready", 32'(bus.wdata_ready), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [10:0] addr;
      logic [7:0]  wd;
      logic [7:0]  exp;
   } vec_t;
   vec_t vec [7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int kk;
      n_cmp = 0;
      n_mis = 0;
      for (int i = 0; i < 2048; i++) begin
         ram[i]   = 8'h00;
         model[i] = 8'h00;
      end
      for (int i = 0; i < 16; i++) txn_data[i] = 8'h00;

      vec[0] = '{we: 1'b1, addr: 11'h123, wd: 8'hA5, exp: 8'h00};
      vec[1] = '{we: 1'b0, addr: 11'h123, wd: 8'h00, exp: 8'hA5};
      vec[2] = '{we: 1'b0, addr: 11'h7FF, wd: 8'h00, exp: 8'h00};
      vec[3] = '{we: 1'b1, addr: 11'h000, wd: 8'h3C, exp: 8'h00};
      vec[4] = '{we: 1'b0, addr: 11'h000, wd: 8'h00, exp: 8'h3C};
      vec[5] = '{we: 1'b1, addr: 11'h7FF, wd: 8'h77, exp: 8'h00};
      vec[6] = '{we: 1'b0, addr: 11'h7FF, wd: 8'h00, exp: 8'h77};

      // Reset with a write request presented: it must not be accepted.
      rst           = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 11'h055;
      bus.req_len   = 4'd0;
      bus.req_wdata = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         check("rst_cs", 32'(mem_cs), 32'd1);
         check("rst_busy", 32'(bus.busy), 32'd0);
         check("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cs", 32'(mem_cs), 32'd1);
      check("post_rst_rw", 32'(mem_rw), 32'd1);
      check("post_rst_addr", 32'(mem_addr), 32'd0);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("post_rst_no_write", 32'(ram[11'h055]), 32'd0);

      // Directed vectors: write/read, read 0x7FF then write 0x000 with no gap.
      for (int i = 0; i < 7; i++) begin
         txn_data[0] = vec[i].wd;
         do_txn(vec[i].we, vec[i].addr, 4'd0, 1'b0);
         if (!vec[i].we) check("vec_rdata", 32'(first_rd), 32'(vec[i].exp));
      end

      // req_valid held through a read: second request taken in the first IDLE cycle.
      do_txn(1'b0, 11'h123, 4'd0, 1'b1);
      do_txn(1'b0, 11'h123, 4'd0, 1'b0);
      check("hold_accept_wait", 32'(last_wait), 32'd0);
      check("hold_rdata", 32'(first_rd), 32'hA5);

`ifdef RAM_BURST_EN
      // Wrapping 4-beat write burst, then read back.
      for (int i = 0; i < 4; i++) txn_data[i] = 8'(i + 1);
      do_txn(1'b1, 11'h7FE, 4'd3, 1'b0);
      rd_log.delete();
      do_txn(1'b0, 11'h7FE, 4'd3, 1'b0);
      check("burst_rd_count", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) check("burst_rd_data", 32'(rd_log[i]), 32'(i + 1));
      kk = 4;
`else
      kk = 1;
`endif

      // Reset in the middle of a read (beat 2 of a 4-beat burst when bursts exist).
      bus.req_we    = 1'b0;
      bus.req_addr  = 11'h7FE;
      bus.req_len   = 4'd3;
      bus.req_valid = 1'b1;
      check("abort_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      pulses = 0;
      for (int j = 0; j < kk; j++) begin
         if (bus.rsp_valid) pulses++;
         @(negedge clk);
      end
      check("abort_pulses_before", 32'(pulses), 32'(kk == 4 ? 1 : 0));
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_cs", 32'(mem_cs), 32'd1);
      check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      pulses = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (bus.rsp_valid) pulses++;
      end
      check("abort_no_rsp", 32'(pulses), 32'd0);
      do_txn(1'b0, 11'h7FE, 4'd0, 1'b0);
      check("abort_fresh_read", 32'(first_rd), 32'(model[11'h7FE]));

      // Randomized traffic against the reference memory.
      for (int n = 0; n < 40; n++) begin
         logic        we;
         logic [10:0] addr;
         logic [3:0]  len;
         we   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 1) == 1) ? 11'(2047 - $urandom_range(0, 3)) : 11'($urandom);
         len  = 4'($urandom);
         for (int k = 0; k < 16; k++) txn_data[k] = 8'($urandom);
         do_txn(we, addr, len, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
